// File: rtl/bf_rdx2_pair_buf.sv
// Radix-2 DIF input pairing buffer: stores the first half of a frame, then pairs
// each second-half sample x[k+HALF] with x[k] and its twiddle index for the butterfly.
module bf_rdx2_pair_buf #(
  parameter int HALF = 8,
  parameter int DW   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_re,
  input  logic [DW-1:0]     in_im,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     x0_re,
  output logic [DW-1:0]     x0_im,
  output logic [DW-1:0]     x1_re,
  output logic [DW-1:0]     x1_im,
  output logic [$clog2(HALF)-1:0] tw_idx,
  output logic              out_last
);

  localparam int AW = $clog2(HALF);

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] PAIR = 1'b1;

  logic [0:0]    state;
  logic [AW-1:0] cnt;
  logic [DW-1:0] mem_re [HALF];
  logic [DW-1:0] mem_im [HALF];

  logic accept;
  logic cnt_last;

  // Single output register without skid: in PAIR a new sample is only taken
  // when the register is empty or being drained this cycle.
  always_comb begin
    in_ready = 1'b1;
    if (state == PAIR) begin
      in_ready = !out_valid || out_ready;
    end
  end

  assign accept   = in_valid && in_ready;
  assign cnt_last = (cnt == AW'(HALF - 1));

  always_ff @(posedge clk) begin
    if (accept && state == FILL) begin
      mem_re[cnt] <= in_re;
      mem_im[cnt] <= in_im;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
      cnt   <= '0;
    end else if (accept) begin
      cnt <= cnt_last ? '0 : cnt + 1'b1;
      if (cnt_last) begin
        state <= (state == FILL) ? PAIR : FILL;
      end
    end
  end

  // Drain first, then a PAIR accept reloads the register so a simultaneous
  // transfer and load keeps out_valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      x0_re     <= '0;
      x0_im     <= '0;
      x1_re     <= '0;
      x1_im     <= '0;
      tw_idx    <= '0;
      out_last  <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept && state == PAIR) begin
        out_valid <= 1'b1;
        x0_re     <= mem_re[cnt];
        x0_im     <= mem_im[cnt];
        x1_re     <= in_re;
        x1_im     <= in_im;
        tw_idx    <= cnt;
        out_last  <= cnt_last;
      end
    end
  end

endmodule

// File: tb/tb_bf_rdx2_pair_buf.sv
// Self-checking bench for bf_rdx2_pair_buf (HALF=4): a frame-position reference
// model predicts in_ready, out_valid and each emitted pair cycle by cycle.
module tb_bf_rdx2_pair_buf;

  localparam int HALF = 4;
  localparam int DW   = 16;
  localparam int AW   = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_re;
  logic [DW-1:0] in_im;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] x0_re;
  logic [DW-1:0] x0_im;
  logic [DW-1:0] x1_re;
  logic [DW-1:0] x1_im;
  logic [AW-1:0] tw_idx;
  logic          out_last;

  always #5 clk = ~clk;

  bf_rdx2_pair_buf #(.HALF(HALF), .DW(DW)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_re(in_re),
    .in_im(in_im),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .x0_re(x0_re),
    .x0_im(x0_im),
    .x1_re(x1_re),
    .x1_im(x1_im),
    .tw_idx(tw_idx),
    .out_last(out_last)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: position within the 2*HALF frame plus the pending pair.
  int            pos;
  logic [DW-1:0] fr_re [2*HALF];
  logic [DW-1:0] fr_im [2*HALF];
  logic          m_valid;
  logic [DW-1:0] m_x0re, m_x0im, m_x1re, m_x1im;
  logic [AW-1:0] m_tw;
  logic          m_last;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic checkPair();
    checkOutput("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      checkOutput("x0_re", 32'(x0_re), 32'(m_x0re));
      checkOutput("x0_im", 32'(x0_im), 32'(m_x0im));
      checkOutput("x1_re", 32'(x1_re), 32'(m_x1re));
      checkOutput("x1_im", 32'(x1_im), 32'(m_x1im));
      checkOutput("tw_idx", 32'(tw_idx), 32'(m_tw));
      checkOutput("out_last", 32'(out_last), 32'(m_last));
    end
  endtask

  // One clock cycle: drive inputs just after a falling edge, predict, then
  // compare the registered outputs at the next falling edge.
  task automatic applyStimulus(input logic iv, input logic [DW-1:0] re,
                               input logic [DW-1:0] im, input logic ordy);
    logic exp_rdy;
    in_valid  = iv;
    in_re     = re;
    in_im     = im;
    out_ready = ordy;
    #1;
    exp_rdy = (pos < HALF) || !m_valid || ordy;
    checkOutput("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (m_valid && ordy) m_valid = 1'b0;
    if (iv && exp_rdy) begin
      fr_re[pos] = re;
      fr_im[pos] = im;
      if (pos >= HALF) begin
        m_valid = 1'b1;
        m_x0re  = fr_re[pos-HALF];
        m_x0im  = fr_im[pos-HALF];
        m_x1re  = re;
        m_x1im  = im;
        m_tw    = AW'(pos - HALF);
        m_last  = (pos == 2*HALF - 1);
      end
      pos = (pos + 1) % (2*HALF);
    end
    @(negedge clk);
    checkPair();
  endtask

  task automatic resetDut();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_re     = '0;
    in_im     = '0;
    out_ready = 1'b0;
    @(negedge clk);
    rst     = 1'b0;
    pos     = 0;
    m_valid = 1'b0;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_tw_idx", 32'(tw_idx), 32'd0);
    checkOutput("rst_out_last", 32'(out_last), 32'd0);
    checkOutput("rst_x0", {x0_re, x0_im}, 32'd0);
    checkOutput("rst_x1", {x1_re, x1_im}, 32'd0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b1);
  endtask

  initial begin
    logic [DW-1:0] ext_a, ext_b;
    resetDut();

    $display("[TB] basic frame, out_ready=1");
    for (int k = 0; k < 2*HALF; k++) applyStimulus(1'b1, DW'(k), DW'(-k), 1'b1);
    drain(2);

    $display("[TB] stall at pair 2");
    for (int k = 0; k < 7; k++) applyStimulus(1'b1, DW'(k), DW'(-k), 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, DW'(7), DW'(-7), 1'b0);
    applyStimulus(1'b1, DW'(7), DW'(-7), 1'b1);
    drain(2);

    $display("[TB] three back-to-back frames");
    for (int k = 0; k < 6*HALF; k++) applyStimulus(1'b1, DW'(100 + k), DW'(-(100 + k)), 1'b1);
    drain(2);

    $display("[TB] random gaps and backpressure");
    for (int i = 0; i < 300; i++)
      applyStimulus(1'($urandom_range(0, 1)), DW'($urandom), DW'($urandom), 1'($urandom_range(0, 1)));
    drain(2);

    $display("[TB] reset mid-frame");
    for (int k = 0; k < 6; k++) applyStimulus(1'b1, DW'(k), DW'(-k), 1'b0);
    resetDut();
    for (int k = 10; k < 18; k++) applyStimulus(1'b1, DW'(k), DW'(-k), 1'b1);
    drain(2);

    $display("[TB] extreme values");
    ext_a = 16'h8000;
    ext_b = 16'h7FFF;
    for (int k = 0; k < 2*HALF; k++) begin
      if (((k % 2) == 0) ^ (k >= HALF)) applyStimulus(1'b1, ext_a, ext_b, 1'b1);
      else                              applyStimulus(1'b1, ext_b, ext_a, 1'b1);
    end
    drain(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
